// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types for the two-requester BRAM port arbiter
package bram_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/bram_arb_rr.sv
// bram_arb_rr: combinational two-input round-robin picker
module bram_arb_rr
    import bram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    last_gnt,
    output logic [1:0] gnt
);
    always_comb gnt = {valid[1] & (~valid[0] | ~last_gnt), valid[0] & (~valid[1] | last_gnt)};
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one single-port BRAM between two requesters with
// round-robin grant, locked bursts and read-data routing.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_valid,
    output logic                  rq0_ready,
    input  logic                  rq0_we,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_wdata,
    input  logic                  rq0_lock,
    input  logic                  rq1_valid,
    output logic                  rq1_ready,
    input  logic                  rq1_we,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_wdata,
    input  logic                  rq1_lock,
    output logic                  rs0_valid,
    output logic [DATA_WIDTH-1:0] rs0_data,
    output logic                  rs1_valid,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  grant_id,
    output logic                  busy
);
    localparam int CW = $clog2(MAX_BURST);

    arb_state_t            state;
    req_id_t               last_gnt, sel, pend_id;
    logic [CW-1:0]         burst_cnt;
    logic                  pend_vld, acc, sel_we, sel_lock, release_beat;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] addr_q, sel_addr;

    bram_arb_rr u_rr (
        .valid    ({rq1_valid, rq0_valid} & {2{~rst}}),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    // An owner keeps the port across its own bubbles; the other side stays stalled.
    always_comb begin
        sel          = (state == OWN1) || (state == IDLE && gnt[1]);
        rq0_ready    = !rst && rq0_valid && (state == OWN0 || (state == IDLE && gnt[0]));
        rq1_ready    = !rst && rq1_valid && (state == OWN1 || (state == IDLE && gnt[1]));
        acc          = rq0_ready || rq1_ready;
        sel_we       = sel ? rq1_we : rq0_we;
        sel_lock     = sel ? rq1_lock : rq0_lock;
        sel_addr     = sel ? rq1_addr : rq0_addr;
        release_beat = !sel_lock || burst_cnt == CW'(MAX_BURST - 1);
        mem_we       = acc && sel_we;
        mem_addr     = acc ? sel_addr : addr_q;
        mem_din      = sel ? rq1_wdata : rq0_wdata;
        grant_id     = sel;
        rs0_valid    = pend_vld && !pend_id;
        rs1_valid    = pend_vld && pend_id;
        rs0_data     = rs0_valid ? mem_dout : '0;
        rs1_data     = rs1_valid ? mem_dout : '0;
        busy         = state != IDLE || pend_vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            burst_cnt <= '0;
            pend_vld  <= 1'b0;
            pend_id   <= 1'b0;
            addr_q    <= '0;
        end else begin
            pend_vld <= acc && !sel_we;
            pend_id  <= sel;
            if (acc) begin
                addr_q <= sel_addr;
                if (release_beat) begin
                    state     <= IDLE;
                    last_gnt  <= sel;
                    burst_cnt <= '0;
                end else begin
                    state     <= sel ? OWN1 : OWN0;
                    burst_cnt <= burst_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed vectors with a response scoreboard and a
// behavioural single-port BRAM (registered read, no read on write cycles).
module tb_bram_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq0_valid = 0, rq0_we = 0, rq0_lock = 0;
    logic        rq1_valid = 0, rq1_we = 0, rq1_lock = 0;
    logic [9:0]  rq0_addr = 0, rq1_addr = 0;
    logic [15:0] rq0_wdata = 0, rq1_wdata = 0;
    logic        rq0_ready, rq1_ready, rs0_valid, rs1_valid, mem_we, grant_id, busy;
    logic [15:0] rs0_data, rs1_data, mem_din, mem_dout;
    logic [9:0]  mem_addr;

    int total = 0;
    int bad = 0;
    logic        done = 1'b0;
    logic        preload = 1'b1;
    logic [15:0] bram [1024];
    logic [15:0] exp_mem [1024];
    logic [15:0] q0[$], q1[$];

    always #5 clk = ~clk;

    bram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_we(rq0_we), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_lock(rq0_lock),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_we(rq1_we), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_lock(rq1_lock),
        .rs0_valid(rs0_valid), .rs0_data(rs0_data), .rs1_valid(rs1_valid), .rs1_data(rs1_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .grant_id(grant_id), .busy(busy)
    );

    function automatic logic [15:0] init_val(input int i);
        return (i == 5) ? 16'hBEEF : (16'(i) ^ 16'hA5A5);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) bram[i] <= init_val(i);
        end else if (mem_we) begin
            bram[mem_addr] <= mem_din;
        end else begin
            mem_dout <= bram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            if (rs0_valid) begin
                if (q0.size() == 0) chk("rs0_unexpected", 1, 0);
                else chk("rs0_data", rs0_data, q0.pop_front());
                chk("rs1_data_zero", rs1_data, 0);
            end
            if (rs1_valid) begin
                if (q1.size() == 0) chk("rs1_unexpected", 1, 0);
                else chk("rs1_data", rs1_data, q1.pop_front());
                chk("rs0_data_zero", rs0_data, 0);
            end
        end
    end

    // Drives one cycle of requests, checks the grant at the negedge and records expectations.
    task automatic cyc(input logic v0, input logic w0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic l0, input logic v1, input logic w1, input logic [9:0] a1,
                       input logic [15:0] d1, input logic l1, input logic e0, input logic e1);
        logic s, w;
        logic [9:0] a;
        logic [15:0] d;
        rq0_valid = v0; rq0_we = w0; rq0_addr = a0; rq0_wdata = d0; rq0_lock = l0;
        rq1_valid = v1; rq1_we = w1; rq1_addr = a1; rq1_wdata = d1; rq1_lock = l1;
        @(negedge clk);
        chk("rq0_ready", rq0_ready, e0);
        chk("rq1_ready", rq1_ready, e1);
        if (e0 || e1) begin
            s = e1;
            w = s ? w1 : w0;
            a = s ? a1 : a0;
            d = s ? d1 : d0;
            chk("mem_we", mem_we, w);
            chk("mem_addr", mem_addr, a);
            chk("grant_id", grant_id, s);
            if (w) begin
                chk("mem_din", mem_din, d);
                exp_mem[a] = d;
            end else if (s) q1.push_back(exp_mem[a]);
            else q0.push_back(exp_mem[a]);
        end else chk("mem_we_idle", mem_we, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
        rq0_valid = 1'b1;
        rq1_valid = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_rq0_ready", rq0_ready, 0);
        chk("rst_rq1_ready", rq1_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rs_valid", {rs1_valid, rs0_valid}, 0);
        chk("rst_grant_id", grant_id, 0);
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_grant_id", grant_id, 0);
        @(posedge clk);
        #1;

        // single read of the preloaded word
        cyc(1, 0, 10'h005, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("busy_pending", busy, 1);
        idle(2);

        // ties alternate starting with requester 0 after reset
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 10'h010, 0, 0, 1, 0, 10'h020, 0, 0, i % 2 == 0, i % 2 == 1);

        // locked write burst, then requester 1 reads back the last written word
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 10'(10'h100 + i), 16'(16'h1000 + i), i < 3, 1, 0, 10'h103, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 10'h103, 0, 0, 0, 1);

        // continuous lock is cut after four beats, requester 1 gets one slot
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 10'(10'h200 + i), 16'(16'h2000 + i), 1, 1, 0, 10'h103, 0, 0, 1, 0);
        cyc(1, 1, 10'h204, 16'h2004, 1, 1, 0, 10'h103, 0, 0, 0, 1);
        cyc(1, 1, 10'h204, 16'h2004, 1, 1, 0, 10'h103, 0, 0, 1, 0);
        cyc(1, 1, 10'h205, 16'h2005, 0, 0, 0, 0, 0, 0, 1, 0);

        // requester 1 keeps the lock through a three-cycle bubble
        cyc(1, 0, 10'h010, 0, 0, 1, 1, 10'h300, 16'h3000, 1, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 10'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 10'h010, 0, 0, 1, 1, 10'h301, 16'h3001, 0, 0, 1);
        cyc(1, 0, 10'h300, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 10'h200, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        // async reset between edges with a read response pending
        cyc(1, 0, 10'h005, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        rq1_valid = 1'b1;
        rq1_addr = 10'h020;
        #1 rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("arst_rs0_valid", rs0_valid, 0);
        chk("arst_rq0_ready", rq0_ready, 0);
        chk("arst_rq1_ready", rq1_ready, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 10'h010, 0, 0, 1, 0, 10'h020, 0, 0, 1, 0);
        cyc(1, 0, 10'h010, 0, 0, 1, 0, 10'h020, 0, 0, 0, 1);
        idle(2);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer for one single-port BRAM (registered read, 1-cycle latency, no read on write cycles) in the DNN pipeline. Shares the weight/activation BRAM between the layer-load engine (requester 0) and the compute engine (requester 1). Uses round-robin grant with optional locked bursts. Drives the BRAM address/data/write-enable and routes read data back to the issuing requester.

## Interface
- ADDR_WIDTH, 10, BRAM address width
- DATA_WIDTH, 16, BRAM word width
- MAX_BURST, 16, maximum consecutive locked beats per grant (≥2)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rq0_valid / rq1_valid  in  1  request present
- rq0_ready / rq1_ready  out  1  request accepted this cycle (combinational from state and valids)
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_WIDTH  word address
- rq0_wdata / rq1_wdata  in  DATA_WIDTH  write data
- rq0_lock / rq1_lock  in  1  keep grant after this beat
- rs0_valid / rs1_valid  out  1  read data valid, no backpressure
- rs0_data / rs1_data  out  DATA_WIDTH  read data
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_din  out  DATA_WIDTH  BRAM write data
- mem_dout  in  DATA_WIDTH  BRAM registered read data
- grant_id  out  1  requester owning the port (valid while busy)
- busy  out  1  state ≠ IDLE or a read response is pending

## Operation
- A beat transfers when rqX_valid && rqX_ready. At most one beat per cycle.
- mem_we = accepted && rqX_we. mem_addr and mem_din are muxed from the granted requester. When nothing is accepted, mem_we=0 and mem_addr holds its last value; the BRAM then performs a harmless read.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: one valid → grant it. Both valid → grant the requester not in last_gnt.
  - Accepted beat with lock=1 → next state OWNx, burst_cnt+1.
  - Accepted beat with lock=0 → IDLE, last_gnt=x.
- OWNx: only rqx_ready may be 1. The other requester is stalled even if rqx_valid=0, because the lock holds across owner bubbles.
  - Accepted beat with lock=0 → IDLE, last_gnt=x.
  - Accepted beat with lock=1 and burst_cnt==MAX_BURST-1 → forced release to IDLE, last_gnt=x. The other requester wins the next tie.
- Read response: an accepted read sets pend_vld, pend_id for the next cycle. rs<pend_id>_valid=1 and rs<pend_id>_data=mem_dout. The other rs_data is driven 0.
- Writes produce no response. A read in cycle N+1 to an address written in cycle N returns the new data.

## Timing
- Reset (async assert): state=IDLE, last_gnt=1 (requester 0 wins the first tie), burst_cnt=0, pend_vld=0.
  - rs0_valid=rs1_valid=0, busy=0, grant_id=0, mem_addr=0.
  - mem_we=0 and rq*_ready=0 while rst is asserted.
  - A pending response is dropped. The lock is cleared.
- Read latency: accept at edge N → rsX_valid high for exactly the cycle after edge N+1. Back-to-back reads give one response per cycle.
- Throughput: 1 beat/cycle. A grant switch costs 0 cycles in IDLE because the decision is combinational from valids.
- Requester valid may drop without a handshake. Fields must be stable only in the accept cycle.
- burst_cnt is ceil(log2(MAX_BURST)) bits, saturates at MAX_BURST-1, and clears on release.

## Structure
- Package bram_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - typedef logic req_id_t
- Sub-module bram_arb_rr: combinational 2-input round-robin picker (valids, last_gnt → gnt one-hot).
- Top holds the FSM, burst counter, response pipeline register, and muxes. Expected size is 150–250 lines.

## Test plan
- Single read: after reset, rq0 read addr 0x005 (BRAM preloaded 0xBEEF) → rq0_ready=1 same cycle, mem_addr=0x005, rs0_valid=1 one cycle later with 0xBEEF, rs1_valid=0.
- Tie: both valid reads, addrs 0x010 and 0x020, held 4 cycles → grants alternate 0,1,0,1. Responses appear on rs0/rs1 in the same order, one cycle after each grant.
- Locked burst: rq0 writes 0x100–0x103 with lock=1,1,1,0 while rq1 is valid → rq1_ready=0 for all 4 beats, rq1 is granted on cycle 5, and a read of 0x103 returns the written value.
- Forced release: MAX_BURST=4, rq0 holds lock=1 continuously with rq1 valid → rq0 gets exactly 4 beats, rq1 gets the 5th cycle, then rq0 resumes.
- Owner bubble: rq1 locked, drops valid for 3 cycles, rq0 valid → rq0_ready stays 0 and mem_we=0 throughout. rq1 resumes and completes with lock=0, then rq0 is granted.
- Async reset mid-burst: assert rst between clock edges with a read pending → rs*_valid drops immediately, rq*_ready=0, and after release the first tie goes to rq0.
